// File: rtl/mc_pkg.sv
// Shared definitions for the multi-cycle RV32I sequencer: state encoding,
// opcode constants, error codes and writeback-mux selects.
package mc_pkg;

    typedef enum logic [2:0] {
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_MEM,
        ST_WB,
        ST_HALT
    } state_t;

    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_ILLEGAL = 2'd1;
    localparam logic [1:0] ERR_IMEM_TO = 2'd2;
    localparam logic [1:0] ERR_DMEM_TO = 2'd3;

    localparam logic [1:0] WB_DMEM = 2'd0;
    localparam logic [1:0] WB_ALU  = 2'd1;
    localparam logic [1:0] WB_PC4  = 2'd2;

    function automatic logic is_jump(input logic [6:0] op);
        return (op == OPC_JAL) || (op == OPC_JALR);
    endfunction

endpackage

// File: rtl/mc_wait_timer.sv
// Memory-handshake wait counter; expired flags the last wait cycle allowed
// before a timeout. MAX_WAIT = 0 means unbounded and builds no flops.
module mc_wait_timer #(
    parameter int unsigned MAX_WAIT = 0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic wait_en,
    output logic expired
);

    generate
        if (MAX_WAIT == 0) begin : g_unbounded
            logic unused_inputs;
            assign unused_inputs = ^{clk, rst_n, clear, wait_en};
            assign expired       = 1'b0;
        end else begin : g_bounded
            localparam int unsigned CW = $clog2(MAX_WAIT + 1);
            logic [CW-1:0] count;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    count <= '0;
                end else if (clear) begin
                    count <= '0;
                end else if (wait_en && (count != CW'(MAX_WAIT))) begin
                    count <= count + CW'(1);
                end
            end

            // Asserted on the MAX_WAIT-th waiting cycle; a ready seen that cycle still wins.
            assign expired = (count == CW'(MAX_WAIT - 1));
        end
    endgenerate

endmodule

// File: rtl/multi_cycle_seq.sv
// Multi-cycle RV32I sequencer: FETCH/DECODE/EXEC/MEM/WB control strobes,
// timeout/illegal halt. Perf counters are built only with MC_PERF_CNT_EN.
module multi_cycle_seq
    import mc_pkg::*;
#(
    parameter int unsigned CNT_W    = 32,
    parameter int unsigned MAX_WAIT = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [6:0]       opcode,
    input  logic             br_taken,
    input  logic             imem_ready,
    input  logic             dmem_ready,
    output logic             imem_req,
    output logic             ir_we,
    output logic             dmem_req,
    output logic             dmem_we,
    output logic             reg_we,
    output logic [1:0]       wb_sel,
    output logic             pc_we,
    output logic             pc_sel,
    output logic             retire,
    output logic             halted,
    output logic [1:0]       err_code,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instret_cnt
);

    state_t     state, state_next;
    logic [1:0] err_q, err_next;
    logic       go_halt;
    logic       imem_req_c, ir_we_c, dmem_req_c, dmem_we_c, reg_we_c;
    logic       pc_we_c, pc_sel_c, retire_c;
    logic [1:0] wb_sel_c;
    logic       wait_clear, wait_en, expired;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_FETCH;
            err_q <= ERR_NONE;
        end else begin
            state <= state_next;
            if (go_halt) begin
                err_q <= err_next;
            end
        end
    end

    always_comb begin
        state_next = state;
        err_next   = ERR_NONE;
        go_halt    = 1'b0;
        imem_req_c = 1'b0;
        ir_we_c    = 1'b0;
        dmem_req_c = 1'b0;
        dmem_we_c  = 1'b0;
        reg_we_c   = 1'b0;
        wb_sel_c   = WB_DMEM;
        pc_we_c    = 1'b0;
        pc_sel_c   = 1'b0;
        retire_c   = 1'b0;

        case (state)
            ST_FETCH: begin
                imem_req_c = 1'b1;
                if (imem_ready) begin
                    ir_we_c    = 1'b1;
                    state_next = ST_DECODE;
                end else if (expired) begin
                    state_next = ST_HALT;
                    err_next   = ERR_IMEM_TO;
                    go_halt    = 1'b1;
                end
            end
            ST_DECODE: state_next = ST_EXEC;
            ST_EXEC: begin
                case (opcode)
                    OPC_BRANCH: begin
                        pc_we_c    = 1'b1;
                        pc_sel_c   = br_taken;
                        retire_c   = 1'b1;
                        state_next = ST_FETCH;
                    end
                    OPC_LOAD, OPC_STORE: state_next = ST_MEM;
                    OPC_OP, OPC_OP_IMM, OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR:
                        state_next = ST_WB;
                    OPC_MISC_MEM: begin
                        pc_we_c    = 1'b1;
                        retire_c   = 1'b1;
                        state_next = ST_FETCH;
                    end
                    OPC_SYSTEM: begin
                        state_next = ST_HALT;
                        err_next   = ERR_NONE;
                        go_halt    = 1'b1;
                    end
                    default: begin
                        state_next = ST_HALT;
                        err_next   = ERR_ILLEGAL;
                        go_halt    = 1'b1;
                    end
                endcase
            end
            ST_MEM: begin
                // Only LOAD and STORE reach MEM, so non-store implies load.
                dmem_req_c = 1'b1;
                dmem_we_c  = (opcode == OPC_STORE);
                if (dmem_ready) begin
                    if (opcode == OPC_STORE) begin
                        pc_we_c    = 1'b1;
                        retire_c   = 1'b1;
                        state_next = ST_FETCH;
                    end else begin
                        state_next = ST_WB;
                    end
                end else if (expired) begin
                    state_next = ST_HALT;
                    err_next   = ERR_DMEM_TO;
                    go_halt    = 1'b1;
                end
            end
            ST_WB: begin
                reg_we_c   = 1'b1;
                if (opcode == OPC_LOAD) begin
                    wb_sel_c = WB_DMEM;
                end else if (is_jump(opcode)) begin
                    wb_sel_c = WB_PC4;
                end else begin
                    wb_sel_c = WB_ALU;
                end
                pc_we_c    = 1'b1;
                pc_sel_c   = is_jump(opcode);
                retire_c   = 1'b1;
                state_next = ST_FETCH;
            end
            ST_HALT: state_next = ST_HALT;
            default: state_next = ST_FETCH;
        endcase
    end

    assign wait_en    = ((state == ST_FETCH) && !imem_ready) ||
                        ((state == ST_MEM)   && !dmem_ready);
    assign wait_clear = (state_next != state) &&
                        ((state_next == ST_FETCH) || (state_next == ST_MEM));

    mc_wait_timer #(
        .MAX_WAIT (MAX_WAIT)
    ) u_wait_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (wait_clear),
        .wait_en (wait_en),
        .expired (expired)
    );

    // Strobes are gated by rst_n so an aborted instruction cannot write during reset.
    assign imem_req = imem_req_c & rst_n;
    assign ir_we    = ir_we_c    & rst_n;
    assign dmem_req = dmem_req_c & rst_n;
    assign dmem_we  = dmem_we_c  & rst_n;
    assign reg_we   = reg_we_c   & rst_n;
    assign wb_sel   = rst_n ? wb_sel_c : WB_DMEM;
    assign pc_we    = pc_we_c    & rst_n;
    assign pc_sel   = pc_sel_c   & rst_n;
    assign retire   = retire_c   & rst_n;
    assign halted   = (state == ST_HALT) & rst_n;
    assign err_code = err_q;

`ifdef MC_PERF_CNT_EN
    logic [CNT_W-1:0] cycle_q, instret_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_q   <= '0;
            instret_q <= '0;
        end else begin
            cycle_q <= cycle_q + CNT_W'(1);
            if (retire_c) begin
                instret_q <= instret_q + CNT_W'(1);
            end
        end
    end

    assign cycle_cnt   = cycle_q;
    assign instret_cnt = instret_q;
`else
    assign cycle_cnt   = '0;
    assign instret_cnt = '0;
`endif

endmodule
